enemy_pool: RTL and testbench

- Parametrised object-pool manager for the enemy planes.
- Keeps N_SLOTS sprite slots (active flag, x, y).
- Spawns enemies at pseudo-random x positions on a frame-count timer, moves them down once per frame, and retires them on a kill or when they leave the screen.
- Answers per-pixel display queries from the display controller with a hit flag, slot index and sprite-local coordinates for sprite ROM addressing.

---
 rtl/enemy_pool.sv | 153 +++++++++++++++
 tb/tb_enemy_pool.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_pool.sv
// enemy_pool: object pool for enemy sprites -- timed spawn, per-frame move, retire, per-pixel hit query
// Ports: clk, rst (sync, active-low); frame_tick_i, run_i, clear_i control the pool;
// kill_valid_i/kill_idx_i retire one slot; req_x_addr_i/req_y_addr_i query a pixel and get
// hit_o, hit_idx_o, spr_x_o, spr_y_o one cycle later; active_o per-slot flags;
// escape_o and spawn_drop_o are single-cycle event pulses.
module enemy_pool #(
  parameter int N_SLOTS = 8,
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int H_RES = 800,
  parameter int V_RES = 600,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int SPEED = 2,
  parameter int SPAWN_PERIOD = 60,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int IDX_W = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1,
  localparam int SX_W = $clog2(SPR_W),
  localparam int SY_W = $clog2(SPR_H)
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick_i,
  input  logic run_i,
  input  logic clear_i,
  input  logic kill_valid_i,
  input  logic [IDX_W-1:0] kill_idx_i,
  input  logic [X_W-1:0] req_x_addr_i,
  input  logic [Y_W-1:0] req_y_addr_i,
  output logic hit_o,
  output logic [IDX_W-1:0] hit_idx_o,
  output logic [SX_W-1:0] spr_x_o,
  output logic [SY_W-1:0] spr_y_o,
  output logic [N_SLOTS-1:0] active_o,
  output logic escape_o,
  output logic spawn_drop_o
);
  localparam logic [15:0] RELOAD = 16'(SPAWN_PERIOD - 1);
  localparam logic [X_W:0] XMAX = (X_W+1)'(H_RES - SPR_W + 1);
  localparam logic [X_W:0] SW = (X_W+1)'(SPR_W);
  localparam logic [Y_W:0] SH = (Y_W+1)'(SPR_H);
  localparam logic [Y_W:0] STEP = (Y_W+1)'(SPEED);
  localparam logic [Y_W:0] VMAX = (Y_W+1)'(V_RES);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [15:0] cnt;
  logic [N_SLOTS-1:0] act;
  logic [X_W-1:0] xs [N_SLOTS];
  logic [Y_W-1:0] ys [N_SLOTS];
  logic live;
  logic spawn_due;
  logic [N_SLOTS-1:0] kill_hot;
  logic [N_SLOTS-1:0] esc_hot;
  logic [N_SLOTS-1:0] act_nxt;
  logic [Y_W:0] y_next [N_SLOTS];
  logic found;
  logic [IDX_W-1:0] free_idx;
  logic [X_W:0] l0;
  logic [X_W:0] l1;
  logic [X_W-1:0] spawn_x;
  logic q_hit;
  logic [IDX_W-1:0] q_idx;
  logic [SX_W-1:0] q_dx;
  logic [SY_W-1:0] q_dy;
  assign active_o = act;
  // move and spawn only happen on a frame tick while running
  assign live = state == RUN && run_i && frame_tick_i;
  assign spawn_due = live && cnt == '0;
  always_comb begin
    kill_hot = '0;
    if (kill_valid_i && int'(kill_idx_i) < N_SLOTS) kill_hot[kill_idx_i] = 1'b1;
  end
  // y is widened by one bit so y+SPEED never wraps before the bottom test;
  // a killed slot neither moves nor escapes
  for (genvar i = 0; i < N_SLOTS; i++) begin : g_move
    assign y_next[i] = {1'b0, ys[i]} + STEP;
    assign esc_hot[i] = act[i] && !kill_hot[i] && y_next[i] >= VMAX;
  end
  // only slots free before this edge are spawn candidates, so use the registered flags
  always_comb begin
    found = 1'b0;
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (!act[i]) begin
        found = 1'b1;
        free_idx = IDX_W'(i);
      end
  end
  // fold the LFSR value into 0..H_RES-SPR_W with up to two conditional subtracts
  assign l0 = {1'b0, lfsr[X_W-1:0]};
  assign l1 = l0 >= XMAX ? l0 - XMAX : l0;
  assign spawn_x = X_W'(l1 >= XMAX ? l1 - XMAX : l1);
  // spawn bit is applied after kill/escape so a freshly freed slot cannot be refilled this cycle
  always_comb begin
    act_nxt = act & ~kill_hot & ~(live ? esc_hot : '0);
    if (spawn_due && found) act_nxt[free_idx] = 1'b1;
  end
  // descending scan leaves the lowest hitting slot selected
  always_comb begin
    q_hit = 1'b0;
    q_idx = '0;
    q_dx = '0;
    q_dy = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (act[i] && {1'b0, req_x_addr_i} >= {1'b0, xs[i]} && {1'b0, req_x_addr_i} < {1'b0, xs[i]} + SW &&
          {1'b0, req_y_addr_i} >= {1'b0, ys[i]} && {1'b0, req_y_addr_i} < {1'b0, ys[i]} + SH) begin
        q_hit = 1'b1;
        q_idx = IDX_W'(i);
        q_dx = SX_W'({1'b0, req_x_addr_i} - {1'b0, xs[i]});
        q_dy = SY_W'({1'b0, req_y_addr_i} - {1'b0, ys[i]});
      end
  end
  always_ff @(posedge clk) begin
    lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    escape_o <= 1'b0;
    spawn_drop_o <= 1'b0;
    hit_o <= q_hit;
    hit_idx_o <= q_idx;
    spr_x_o <= q_dx;
    spr_y_o <= q_dy;
    if (!rst) begin
      lfsr <= LFSR_SEED;
      cnt <= RELOAD;
      state <= IDLE;
      act <= '0;
      hit_o <= 1'b0;
      hit_idx_o <= '0;
      spr_x_o <= '0;
      spr_y_o <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else if (clear_i || state == FLUSH) begin
      act <= '0;
      cnt <= RELOAD;
      state <= clear_i ? FLUSH : IDLE;
    end else begin
      state <= run_i ? RUN : IDLE;
      act <= act_nxt;
      escape_o <= live && |esc_hot;
      spawn_drop_o <= spawn_due && !found;
      if (live) cnt <= cnt == '0 ? RELOAD : cnt - 16'd1;
      for (int i = 0; i < N_SLOTS; i++)
        if (live && act[i] && !kill_hot[i] && !esc_hot[i]) ys[i] <= y_next[i][Y_W-1:0];
      if (spawn_due && found) begin
        xs[free_idx] <= spawn_x;
        ys[free_idx] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_enemy_pool.sv
// tb_enemy_pool: two pools (spawn period 60 and 1) driven in lockstep against a behavioural model
module tb_enemy_pool;
  logic clk = 0;
  logic rst = 0;
  logic frame_tick = 0;
  logic run = 0;
  logic clear = 0;
  logic kill_valid = 0;
  logic [2:0] kill_idx = 0;
  logic [9:0] req_x = 0;
  logic [9:0] req_y = 0;
  logic [1:0] hit;
  logic [1:0] esc;
  logic [1:0] drop;
  logic [1:0][2:0] hidx;
  logic [1:0][4:0] sx;
  logic [1:0][4:0] sy;
  logic [1:0][7:0] act_o;
  int total = 0;
  int bad = 0;
  bit m_act [2][8];
  int m_x [2][8];
  int m_y [2][8];
  int m_cnt [2];
  int m_md [2];
  int m_lf [2];
  bit e_hit [2];
  int e_idx [2];
  int e_sx [2];
  int e_sy [2];
  bit e_esc [2];
  bit e_drop [2];
  always #5 clk = ~clk;
  enemy_pool u0 (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick), .run_i(run), .clear_i(clear),
    .kill_valid_i(kill_valid), .kill_idx_i(kill_idx), .req_x_addr_i(req_x), .req_y_addr_i(req_y),
    .hit_o(hit[0]), .hit_idx_o(hidx[0]), .spr_x_o(sx[0]), .spr_y_o(sy[0]),
    .active_o(act_o[0]), .escape_o(esc[0]), .spawn_drop_o(drop[0])
  );
  enemy_pool #(.SPAWN_PERIOD(1)) u1 (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick), .run_i(run), .clear_i(clear),
    .kill_valid_i(kill_valid), .kill_idx_i(kill_idx), .req_x_addr_i(req_x), .req_y_addr_i(req_y),
    .hit_o(hit[1]), .hit_idx_o(hidx[1]), .spr_x_o(sx[1]), .spr_y_o(sy[1]),
    .active_o(act_o[1]), .escape_o(esc[1]), .spawn_drop_o(drop[1])
  );
  function automatic logic [7:0] m_vec(int d);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_act[d][i];
    return v;
  endfunction
  // mode: 0 idle, 1 run, 2 flush
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int per;
      int l;
      bit pre [8];
      bit go;
      bit found;
      per = d == 0 ? 60 : 1;
      e_hit[d] = 0; e_idx[d] = 0; e_sx[d] = 0; e_sy[d] = 0; e_esc[d] = 0; e_drop[d] = 0;
      for (int i = 7; i >= 0; i--)
        if (m_act[d][i] && int'(req_x) >= m_x[d][i] && int'(req_x) < m_x[d][i] + 32 &&
            int'(req_y) >= m_y[d][i] && int'(req_y) < m_y[d][i] + 32) begin
          e_hit[d] = 1; e_idx[d] = i; e_sx[d] = int'(req_x) - m_x[d][i]; e_sy[d] = int'(req_y) - m_y[d][i];
        end
      l = m_lf[d] % 1024;
      m_lf[d] = (m_lf[d] >> 1) | (((m_lf[d] ^ (m_lf[d] >> 2) ^ (m_lf[d] >> 3) ^ (m_lf[d] >> 5)) & 1) << 15);
      if (!rst) begin
        e_hit[d] = 0; e_idx[d] = 0; e_sx[d] = 0; e_sy[d] = 0;
        for (int i = 0; i < 8; i++) begin m_act[d][i] = 0; m_x[d][i] = 0; m_y[d][i] = 0; end
        m_cnt[d] = per - 1; m_md[d] = 0; m_lf[d] = 16'hACE1;
      end else if (clear || m_md[d] == 2) begin
        for (int i = 0; i < 8; i++) m_act[d][i] = 0;
        m_cnt[d] = per - 1;
        m_md[d] = clear ? 2 : 0;
      end else begin
        go = m_md[d] == 1 && run && frame_tick;
        m_md[d] = run ? 1 : 0;
        for (int i = 0; i < 8; i++) pre[i] = m_act[d][i];
        if (kill_valid) m_act[d][kill_idx] = 0;
        if (go) begin
          for (int i = 0; i < 8; i++)
            if (pre[i] && !(kill_valid && kill_idx == i)) begin
              if (m_y[d][i] + 2 >= 600) begin m_act[d][i] = 0; e_esc[d] = 1; end
              else m_y[d][i] += 2;
            end
          if (m_cnt[d] == 0) begin
            m_cnt[d] = per - 1;
            found = 0;
            for (int i = 0; i < 8; i++)
              if (!found && !pre[i]) begin
                found = 1; m_act[d][i] = 1; m_y[d][i] = 0; m_x[d][i] = l % 769;
              end
            if (!found) e_drop[d] = 1;
          end else m_cnt[d]--;
        end
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic tick1();
    frame_tick = 1;
    cyc();
    frame_tick = 0;
  endtask
  task automatic tick_n(int n);
    repeat (n) begin tick1(); cyc(); end
  endtask
  task automatic test_reset();
    rst = 0;
    cyc();
    cyc();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({hit[d], hidx[d], sx[d], sy[d], act_o[d], esc[d], drop[d]} !== '0) begin
        bad++;
        $display("FAIL reset[%0d] got hit=%0d idx=%0d sx=%0d sy=%0d act=%h esc=%0d drop=%0d want all 0",
                 d, hit[d], hidx[d], sx[d], sy[d], act_o[d], esc[d], drop[d]);
      end
    end
    rst = 1;
    run = 1;
    cyc();
  endtask
  task automatic test_first_spawn();
    tick_n(59);
    total++;
    if (act_o[0] !== 8'h00) begin bad++; $display("FAIL spawn_59 act got %h want 00", act_o[0]); end
    tick1();
    total++;
    if (act_o[0] !== 8'h01) begin bad++; $display("FAIL spawn_60 act got %h want 01", act_o[0]); end
    req_x = 10'(m_x[0][0]);
    req_y = 0;
    cyc();
    total++;
    if ({hit[0], hidx[0], sx[0], sy[0]} !== {1'b1, 3'd0, 5'd0, 5'd0}) begin
      bad++;
      $display("FAIL spawn_origin got hit=%0d idx=%0d sx=%0d sy=%0d want 1 0 0 0", hit[0], hidx[0], sx[0], sy[0]);
    end
  endtask
  task automatic test_escape();
    tick_n(299);
    req_x = 10'(m_x[0][0]);
    req_y = 598;
    cyc();
    total++;
    if ({hit[0], hidx[0], sx[0], sy[0], act_o[0][0]} !== {1'b1, 3'd0, 5'd0, 5'd0, 1'b1}) begin
      bad++;
      $display("FAIL escape_y598 got hit=%0d idx=%0d sx=%0d sy=%0d act0=%0d want 1 0 0 0 1",
               hit[0], hidx[0], sx[0], sy[0], act_o[0][0]);
    end
    tick1();
    total++;
    if ({act_o[0], esc[0]} !== {8'h3E, 1'b1}) begin
      bad++; $display("FAIL escape_edge got act=%h esc=%0d want 3e 1", act_o[0], esc[0]);
    end
    cyc();
    total++;
    if (esc[0] !== 1'b0) begin bad++; $display("FAIL escape_pulse got esc=%0d want 0", esc[0]); end
  endtask
  task automatic test_fill();
    rst = 0;
    cyc();
    rst = 1;
    cyc();
    for (int k = 0; k < 8; k++) begin
      tick1();
      total++;
      if (act_o[1] !== 8'((1 << (k + 1)) - 1)) begin
        bad++; $display("FAIL fill_%0d act got %h want %h", k, act_o[1], 8'((1 << (k + 1)) - 1));
      end
      cyc();
    end
    tick1();
    total++;
    if ({drop[1], act_o[1]} !== {1'b1, 8'hFF}) begin
      bad++; $display("FAIL fill_drop got drop=%0d act=%h want 1 ff", drop[1], act_o[1]);
    end
    cyc();
    total++;
    if (drop[1] !== 1'b0) begin bad++; $display("FAIL drop_pulse got %0d want 0", drop[1]); end
  endtask
  task automatic test_kill_escape();
    tick_n(294);
    kill_valid = 1;
    kill_idx = 3;
    tick1();
    kill_valid = 0;
    total++;
    if ({act_o[1][3], act_o[1][2], esc[1]} !== 3'b010) begin
      bad++;
      $display("FAIL kill_vs_escape got act3=%0d act2=%0d esc=%0d want 0 1 0", act_o[1][3], act_o[1][2], esc[1]);
    end
    cyc();
    tick1();
    total++;
    if ({act_o[1][3], act_o[1][4], esc[1]} !== 3'b101) begin
      bad++;
      $display("FAIL respawn_slot3 got act3=%0d act4=%0d esc=%0d want 1 0 1", act_o[1][3], act_o[1][4], esc[1]);
    end
    cyc();
  endtask
  task automatic test_query();
    int ox [5] = '{0, 31, 32, 0, 25};
    int oy [5] = '{0, 31, 0, 32, 15};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        if (m_act[d][i])
          for (int k = 0; k < 5; k++) begin
            req_x = 10'(m_x[d][i] + ox[k]);
            req_y = 10'(m_y[d][i] + oy[k]);
            cyc();
            for (int e = 0; e < 2; e++) begin
              total++;
              if ({hit[e], hidx[e], sx[e], sy[e]} !== {e_hit[e], 3'(e_idx[e]), 5'(e_sx[e]), 5'(e_sy[e])}) begin
                bad++;
                $display("FAIL query[%0d] (%0d,%0d) got hit=%0d idx=%0d sx=%0d sy=%0d want hit=%0d idx=%0d sx=%0d sy=%0d",
                         e, req_x, req_y, hit[e], hidx[e], sx[e], sy[e], e_hit[e], e_idx[e], e_sx[e], e_sy[e]);
              end
            end
          end
  endtask
  task automatic test_clear();
    tick_n(3);
    clear = 1;
    kill_valid = 1;
    kill_idx = 3'($urandom_range(0, 7));
    frame_tick = 1;
    cyc();
    clear = 0;
    kill_valid = 0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({act_o[d], esc[d], drop[d]} !== '0) begin
        bad++; $display("FAIL clear[%0d] got act=%h esc=%0d drop=%0d want 0 0 0", d, act_o[d], esc[d], drop[d]);
      end
    end
    cyc();
    cyc();
    frame_tick = 0;
    total++;
    if (act_o[1] !== 8'h00) begin bad++; $display("FAIL flush_idle_ticks act got %h want 00", act_o[1]); end
    tick1();
    total++;
    if ({act_o[1], act_o[0]} !== {8'h01, 8'h00}) begin
      bad++; $display("FAIL resume_first got act1=%h act0=%h want 01 00", act_o[1], act_o[0]);
    end
    cyc();
    tick_n(58);
    total++;
    if (act_o[0] !== 8'h00) begin bad++; $display("FAIL resume_59 act got %h want 00", act_o[0]); end
    tick1();
    total++;
    if (act_o[0] !== 8'h01) begin bad++; $display("FAIL resume_60 act got %h want 01", act_o[0]); end
    cyc();
  endtask
  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      int s;
      s = int'($urandom_range(0, 7));
      rst = $urandom_range(0, 999) != 0;
      run = $urandom_range(0, 19) != 0;
      frame_tick = $urandom_range(0, 2) == 0;
      clear = $urandom_range(0, 399) == 0;
      kill_valid = $urandom_range(0, 7) == 0;
      kill_idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        req_x = 10'($urandom_range(0, 799));
        req_y = 10'($urandom_range(0, 629));
      end else begin
        req_x = 10'(m_x[n % 2][s] + int'($urandom_range(0, 34)) - 1);
        req_y = 10'(m_y[n % 2][s] + int'($urandom_range(0, 34)) - 1);
      end
      cyc();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({act_o[d], esc[d], drop[d], hit[d], hidx[d], sx[d], sy[d]} !==
            {m_vec(d), e_esc[d], e_drop[d], e_hit[d], 3'(e_idx[d]), 5'(e_sx[d]), 5'(e_sy[d])}) begin
          bad++;
          $display("FAIL random[%0d] n=%0d got act=%h esc=%0d drop=%0d hit=%0d idx=%0d sx=%0d sy=%0d want act=%h esc=%0d drop=%0d hit=%0d idx=%0d sx=%0d sy=%0d",
                   d, n, act_o[d], esc[d], drop[d], hit[d], hidx[d], sx[d], sy[d],
                   m_vec(d), e_esc[d], e_drop[d], e_hit[d], e_idx[d], e_sx[d], e_sy[d]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_first_spawn();
    test_escape();
    test_fill();
    test_kill_escape();
    test_query();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
